// File: rtl/seg7_frame_decoder_if.sv
// Beat-in / frame-out bundle for seg7_frame_decoder.
// Master drives segment beats and frame_ready; slave returns seg_ready and the decoded frame.
interface seg7_frame_decoder_if;
    logic [7:0]  seg_in;
    logic        seg_valid;
    logic        seg_first;
    logic        seg_ready;
    logic [23:0] d_out;
    logic        frame_valid;
    logic        frame_ready;
    logic        err;
    logic        drop;

    modport master (
        output seg_in, seg_valid, seg_first, frame_ready,
        input  seg_ready, d_out, frame_valid, err, drop
    );

    modport slave (
        input  seg_in, seg_valid, seg_first, frame_ready,
        output seg_ready, d_out, frame_valid, err, drop
    );
endinterface

// File: rtl/seg7_frame_decoder.sv
// Collects six 7-segment beats into a 24-bit hex frame; frame_valid 1 cycle after the 6th beat.
// seg_ready drops while a completed frame waits for frame_ready; stalled partial frames time out.
module seg7_frame_decoder #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_frame_decoder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_count, w_count_nxt;
    logic [19:0] r_word,  w_word_nxt;
    logic        r_inv,   w_inv_nxt;
    logic [23:0] r_d_out, w_d_out_nxt;
    logic        r_err,   w_err_nxt;
    logic [15:0] r_idle,  w_idle_nxt;
    logic        r_drop,  w_drop_nxt;

    logic        w_accept;
    logic        w_bad;
    logic [3:0]  w_nib;
    logic        w_expire;

    assign bus.seg_ready   = (r_state != DONE);
    assign bus.frame_valid = (r_state == DONE);
    assign bus.d_out       = r_d_out;
    assign bus.err         = r_err;
    assign bus.drop        = r_drop;

    assign w_accept = bus.seg_valid && bus.seg_ready;
    assign w_expire = ((32'(r_idle) + 32'd1) == TIMEOUT);

    // Decimal point (bit 7) is not part of the digit.
    always_comb begin
        w_bad = 1'b0;
        w_nib = 4'h0;
        case (bus.seg_in[6:0])
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h67: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_word_nxt  = r_word;
        w_inv_nxt   = r_inv;
        w_d_out_nxt = r_d_out;
        w_err_nxt   = r_err;
        w_idle_nxt  = r_idle;
        w_drop_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && bus.seg_first) begin
                    w_word_nxt  = {16'h0, w_nib};
                    w_count_nxt = 3'd1;
                    w_inv_nxt   = w_bad;
                    w_idle_nxt  = 16'd0;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    w_idle_nxt = 16'd0;
                    if (bus.seg_first) begin
                        w_word_nxt  = {16'h0, w_nib};
                        w_count_nxt = 3'd1;
                        w_inv_nxt   = w_bad;
                    end else if (r_count == 3'd5) begin
                        w_d_out_nxt = {r_word, w_nib};
                        w_err_nxt   = r_inv | w_bad;
                        w_count_nxt = 3'd0;
                        w_state_nxt = DONE;
                    end else begin
                        // Earlier digits shift left so the first beat lands in [23:20].
                        w_word_nxt  = {r_word[15:0], w_nib};
                        w_inv_nxt   = r_inv | w_bad;
                        w_count_nxt = r_count + 3'd1;
                    end
                end else if (w_expire) begin
                    w_idle_nxt  = 16'd0;
                    w_count_nxt = 3'd0;
                    w_inv_nxt   = 1'b0;
                    w_drop_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_idle_nxt = r_idle + 16'd1;
                end
            end
            DONE: begin
                if (bus.frame_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 3'd0;
            r_word  <= 20'h0;
            r_inv   <= 1'b0;
            r_d_out <= 24'h0;
            r_err   <= 1'b0;
            r_idle  <= 16'd0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_word  <= w_word_nxt;
            r_inv   <= w_inv_nxt;
            r_d_out <= w_d_out_nxt;
            r_err   <= w_err_nxt;
            r_idle  <= w_idle_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder with a digit-queue reference model checked every cycle.
module tb_seg7_frame_decoder;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg7_frame_decoder_if bus();

    seg7_frame_decoder #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int fails   = 0;

    // Reference model: a frame is just a list of digits plus a "seen bad pattern" flag.
    logic [6:0]  pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]  m_digits [$];
    bit          m_busy  = 1'b0;
    bit          m_bad   = 1'b0;
    bit          m_hold  = 1'b0;
    int          m_quiet = 0;
    logic [23:0] m_word  = 24'h0;
    logic        m_err   = 1'b0;
    logic        m_drop  = 1'b0;

    function automatic void lookup(input logic [7:0] s, output logic [3:0] nib, output bit bad);
        nib = 4'h0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pats[i] == s[6:0]) begin
                nib = 4'(i);
                bad = 1'b0;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [3:0] nib;
        bit         bad;
        if (reset) begin
            m_digits.delete();
            m_busy = 0; m_bad = 0; m_hold = 0; m_quiet = 0;
            m_word = 24'h0; m_err = 1'b0; m_drop = 1'b0;
        end else begin
            m_drop = 1'b0;
            lookup(bus.seg_in, nib, bad);
            if (m_hold) begin
                if (bus.frame_ready) m_hold = 0;
            end else if (bus.seg_valid && (bus.seg_first || m_busy)) begin
                if (bus.seg_first) begin
                    m_digits.delete();
                    m_bad = 0;
                end
                m_digits.push_back(nib);
                m_bad   = m_bad | bad;
                m_busy  = 1;
                m_quiet = 0;
                if (m_digits.size() == 6) begin
                    m_word = 24'h0;
                    foreach (m_digits[i]) m_word = (m_word << 4) | 24'(m_digits[i]);
                    m_err  = m_bad;
                    m_hold = 1;
                    m_busy = 0;
                end
            end else if (m_busy) begin
                m_quiet++;
                if (m_quiet == TO) begin
                    m_busy = 0;
                    m_drop = 1'b1;
                    m_digits.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (bus.seg_ready !== !m_hold || bus.frame_valid !== m_hold || bus.drop !== m_drop ||
            bus.d_out !== m_word || bus.err !== m_err) begin
            fails++;
            $display("FAIL cycle@%0t: got rdy=%b fv=%b drop=%b d=%h err=%b, expected rdy=%b fv=%b drop=%b d=%h err=%b",
                     $time, bus.seg_ready, bus.frame_valid, bus.drop, bus.d_out, bus.err,
                     !m_hold, m_hold, m_drop, m_word, m_err);
        end
    end

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic beat(input logic [7:0] s, input logic f);
        bus.seg_in    = s;
        bus.seg_valid = 1'b1;
        bus.seg_first = f;
        @(posedge clk); #1;
        bus.seg_valid = 1'b0;
        bus.seg_first = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
        beat(b0, 1'b1); beat(b1, 1'b0); beat(b2, 1'b0);
        beat(b3, 1'b0); beat(b4, 1'b0); beat(b5, 1'b0);
    endtask

    initial begin
        bus.seg_in = 8'h00; bus.seg_valid = 1'b0; bus.seg_first = 1'b0; bus.frame_ready = 1'b1;
        idle(3);
        check("reset_ready", 24'(bus.seg_ready), 24'h1);
        check("reset_dout",  bus.d_out, 24'h0);
        check("reset_fv",    24'(bus.frame_valid), 24'h0);
        reset = 1'b0;
        idle(1);

        frame(8'h5E, 8'h79, 8'h77, 8'h5E, 8'h7C, 8'h79);
        check("deadbe_fv",    24'(bus.frame_valid), 24'h1);
        check("deadbe_dout",  bus.d_out, 24'hDEADBE);
        check("deadbe_model", m_word, 24'hDEADBE);
        check("deadbe_err",   24'(bus.err), 24'h0);
        idle(1);

        frame(8'h86, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD);
        check("dp_dout", bus.d_out, 24'h123456);
        check("dp_err",  24'(bus.err), 24'h0);
        idle(1);

        frame(8'h3F, 8'h06, 8'h00, 8'h4F, 8'h66, 8'h6D);
        check("bad_dout",  bus.d_out, 24'h010345);
        check("bad_err",   24'(bus.err), 24'h1);
        check("bad_model", 24'(m_err), 24'h1);
        idle(1);

        beat(8'h06, 1'b0);
        check("stray_fv", 24'(bus.frame_valid), 24'h0);

        beat(8'h06, 1'b1); beat(8'h5B, 1'b0);
        idle(TO - 1);
        check("to_early", 24'(bus.drop), 24'h0);
        idle(1);
        check("to_drop",  24'(bus.drop), 24'h1);
        check("to_dout",  bus.d_out, 24'h010345);
        idle(1);
        check("to_once",  24'(bus.drop), 24'h0);

        beat(8'h06, 1'b1);
        idle(TO - 1);
        beat(8'h5B, 1'b0);
        check("prio_nodrop", 24'(bus.drop), 24'h0);
        idle(2);
        beat(8'h4F, 1'b0); beat(8'h66, 1'b0); beat(8'h6D, 1'b0); beat(8'h7D, 1'b0);
        check("prio_dout", bus.d_out, 24'h123456);
        idle(1);

        bus.frame_ready = 1'b0;
        beat(8'h06, 1'b1); beat(8'h5B, 1'b0);
        frame(8'h5E, 8'h79, 8'h77, 8'h5E, 8'h7C, 8'h79);
        check("restart_dout", bus.d_out, 24'hDEADBE);
        for (int i = 0; i < 10; i++) begin
            beat(8'h3F, 1'b1);
            check("hold_ready", 24'(bus.seg_ready), 24'h0);
            check("hold_dout",  bus.d_out, 24'hDEADBE);
        end
        bus.frame_ready = 1'b1;
        idle(1);
        check("consumed_fv",   24'(bus.frame_valid), 24'h0);
        check("consumed_dout", bus.d_out, 24'hDEADBE);

        beat(8'h3F, 1'b1); beat(8'h06, 1'b0); beat(8'h5B, 1'b0);
        bus.seg_in = 8'h4F; bus.seg_valid = 1'b1;
        reset = 1'b1;
        idle(1);
        reset = 1'b0; bus.seg_valid = 1'b0;
        check("rst_dout",  bus.d_out, 24'h0);
        check("rst_ready", 24'(bus.seg_ready), 24'h1);
        check("rst_drop",  24'(bus.drop), 24'h0);
        idle(TO + 2);
        frame(8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
        check("zero_fv",   24'(bus.frame_valid), 24'h1);
        check("zero_dout", bus.d_out, 24'h0);
        check("zero_err",  24'(bus.err), 24'h0);
        idle(1);

        bus.frame_ready = 1'b0;
        frame(8'h86, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD);
        check("done_dout", bus.d_out, 24'h123456);
        #2 reset = 1'b1;
        #1;
        check("rstdone_fv",   24'(bus.frame_valid), 24'h0);
        check("rstdone_dout", bus.d_out, 24'h0);
        idle(1);
        reset = 1'b0;
        bus.frame_ready = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/seg7_frame_decoder.md
SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1000: idle cycles in COLLECT without an accepted beat before the partial frame is dropped; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 seg_in  input  8  segment pattern, bit order p g f e d c b a (bit7 = p).
REQ-005 seg_valid  input  1  seg_in is valid this cycle.
REQ-006 seg_first  input  1  qualifies the seg_in beat as the leftmost digit (display5) of a frame.
REQ-007 seg_ready  output  1  block accepts a beat this cycle; a beat is accepted when seg_valid && seg_ready.
REQ-008 d_out  output  24  recovered frame, d_out[23:20] = display5 digit … d_out[3:0] = display0 digit.
REQ-009 frame_valid  output  1  d_out/err hold a completed, unconsumed frame.
REQ-010 frame_ready  input  1  consumer takes the frame when frame_valid && frame_ready.
REQ-011 err  output  1  the frame on d_out contained at least one unrecognised pattern.
REQ-012 drop  output  1  one-cycle pulse: a partial frame was discarded on timeout.

Function
REQ-013 Decode SHALL ignore bit7 and map seg_in[6:0] as: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
REQ-014 Any other seg_in[6:0] SHALL decode to nibble 0 and set the frame's invalid flag.
REQ-015 FSM states SHALL be IDLE, COLLECT, DONE; seg_ready = 1 in IDLE and COLLECT, 0 in DONE.
REQ-016 IDLE: accepted beat with seg_first=1 → store nibble at [23:20], digit count = 1, invalid flag = that beat's flag, go COLLECT.
REQ-017 IDLE: accepted beat with seg_first=0 SHALL be consumed and discarded with no state change.
REQ-018 COLLECT: accepted beat with seg_first=0 → store nibble at position (5 − count), OR its flag into the invalid flag, count+1.
REQ-019 COLLECT: accepted beat with seg_first=1 → restart the frame exactly as REQ-016; no drop pulse.
REQ-020 When the 6th digit is accepted, the next cycle SHALL have state DONE, frame_valid=1, d_out = assembled word, err = invalid flag (latency 1 cycle).
REQ-021 d_out and err SHALL change only on frame completion and hold value otherwise, including after consumption.
REQ-022 DONE: on frame_valid && frame_ready → IDLE next cycle, frame_valid=0, seg_ready=1; without frame_ready, DONE held indefinitely.
REQ-023 Idle counter SHALL clear on every accepted beat and on entry to COLLECT, and increment each COLLECT cycle with no accepted beat.
REQ-024 When the idle counter reaches TIMEOUT → IDLE next cycle, partial frame discarded, drop=1 for exactly that one cycle; d_out/err unchanged.
REQ-025 An accepted beat in the same cycle the counter would reach TIMEOUT SHALL take priority (beat stored, no timeout).
REQ-026 Idle counter SHALL not advance in IDLE or DONE.

Reset
REQ-027 While reset=1: state IDLE, d_out=0, err=0, frame_valid=0, drop=0, count=0, idle counter=0, seg_ready=1.
REQ-028 Reset asserted mid-COLLECT or in DONE SHALL discard all frame contents immediately; no drop pulse.

Verification
REQ-029 Beats 5E(first),79,77,5E,7C,79 back-to-back, frame_ready=1 → frame_valid one cycle after last beat, d_out=24'hDEADBE, err=0.
REQ-030 Beats 86(first),DB,CF,E6,ED,FD (bit7 set) → d_out=24'h123456, err=0.
REQ-031 Frame 3F(first),06,00,4F,66,6D → d_out=24'h010345, err=1.
REQ-032 TIMEOUT=4: 06(first),5B then seg_valid=0 → drop pulses exactly once, 4 cycles after the last accepted beat, state IDLE, d_out unchanged.
REQ-033 06(first),5B, then 5E(first),79,77,5E,7C,79 → d_out=24'hDEADBE, no drop; frame_ready=0 for 10 cycles → seg_ready=0, d_out stable, beats offered during DONE not accepted.
REQ-034 Reset pulsed during the 4th beat of a frame → all outputs at reset values; a following full frame 3F..(0,0,0,0,0,0) yields d_out=0, err=0.
